// File: rtl/raw_window_3x3_pkg.sv
// Shared constants for the raw 3x3 window generator: default pixel width,
// counter width, tap count and the tap indices consumers rely on.
package raw_window_3x3_pkg;

  localparam int DEF_DATA_WIDTH = 10;
  localparam int CNT_W          = 12;
  localparam int WIN_TAPS       = 9;

  // Tap k = 3*i + j; row i=0 is the oldest line, column j=0 the oldest pixel.
  localparam int TAP_TL     = 0;
  localparam int TAP_TR     = 2;
  localparam int TAP_CENTRE = 4;
  localparam int TAP_BL     = 6;
  localparam int TAP_BR     = 8;

  function automatic int tap_lsb(input int k, input int dw);
    return k * dw;
  endfunction

endpackage

// File: rtl/raw_window_3x3_if.sv
// Pixel-in / window-out bundle of the raw 3x3 window generator.
// data_valid_in qualifies data_in for one cycle; there is no ready, the
// source never stalls and a window is lost if the consumer cannot take it.
interface raw_window_3x3_if #(parameter int DATA_WIDTH = 10);
  import raw_window_3x3_pkg::*;

  logic                           data_valid_in;
  logic [DATA_WIDTH-1:0]          data_in;
  logic                           win_valid_out;
  logic [WIN_TAPS*DATA_WIDTH-1:0] win_out;
  logic [CNT_W-1:0]               win_row_out;
  logic [CNT_W-1:0]               win_col_out;
  logic                           frame_done_out;

  modport master (
    output data_valid_in, data_in,
    input  win_valid_out, win_out, win_row_out, win_col_out, frame_done_out
  );

  modport slave (
    input  data_valid_in, data_in,
    output win_valid_out, win_out, win_row_out, win_col_out, frame_done_out
  );

endinterface

// File: rtl/raw_line_ram.sv
// Two-line store packed as one word per column: asynchronous read, synchronous
// write at the same address, so a read in the write cycle returns old data.
module raw_line_ram #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 6,
  parameter int AW    = 3
) (
  input  logic             clk_in,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  // Contents are deliberately not reset; stale lines never reach a valid window.
  always_ff @(posedge clk_in) begin
    if (we) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/raw_window_3x3.sv
// Streaming 3x3 raw neighbourhood generator: raster counters, two-line store
// and a shifting window, emitting one window per pixel with full neighbourhood.
module raw_window_3x3
  import raw_window_3x3_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int HSIZE      = 6,
  parameter int VSIZE      = 6
) (
  input logic             clk_in,
  input logic             rst_n_in,
  raw_window_3x3_if.slave bus
);

  localparam int AW = (HSIZE > 1) ? $clog2(HSIZE) : 1;
  localparam int DW = DATA_WIDTH;

  logic [CNT_W-1:0]       col, row;
  logic                   last_col, last_row, qual;
  logic [DW-1:0]          lb1_rd, lb2_rd;
  logic [WIN_TAPS*DW-1:0] win_q, win_d;

  assign last_col = (col == CNT_W'(HSIZE - 1));
  assign last_row = (row == CNT_W'(VSIZE - 1));
  assign qual     = bus.data_valid_in && (row >= CNT_W'(2)) && (col >= CNT_W'(2));

  // Each entry holds {row r-2, row r-1}; writing {old r-1, new pixel} ages both lines.
  raw_line_ram #(
    .WIDTH (2 * DW),
    .DEPTH (HSIZE),
    .AW    (AW)
  ) u_line_ram (
    .clk_in  (clk_in),
    .we      (bus.data_valid_in),
    .addr    (col[AW-1:0]),
    .wr_data ({lb1_rd, bus.data_in}),
    .rd_data ({lb2_rd, lb1_rd})
  );

  always_comb begin
    win_d = win_q;
    for (int i = 0; i < 3; i++) begin
      win_d[tap_lsb(3*i,   DW) +: DW] = win_q[tap_lsb(3*i+1, DW) +: DW];
      win_d[tap_lsb(3*i+1, DW) +: DW] = win_q[tap_lsb(3*i+2, DW) +: DW];
    end
    win_d[tap_lsb(TAP_TR, DW) +: DW] = lb2_rd;
    win_d[tap_lsb(5, DW)      +: DW] = lb1_rd;
    win_d[tap_lsb(TAP_BR, DW) +: DW] = bus.data_in;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      col <= '0;
      row <= '0;
    end else if (bus.data_valid_in) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + CNT_W'(1);
      end else begin
        col <= col + CNT_W'(1);
      end
    end
  end

  // The window shifts on every accepted pixel so it is already primed at column 2.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      win_q              <= '0;
      bus.win_valid_out  <= 1'b0;
      bus.win_row_out    <= '0;
      bus.win_col_out    <= '0;
      bus.frame_done_out <= 1'b0;
    end else begin
      bus.win_valid_out  <= qual;
      bus.frame_done_out <= bus.data_valid_in && last_col && last_row;
      if (bus.data_valid_in) win_q <= win_d;
      if (qual) begin
        bus.win_row_out <= row - CNT_W'(1);
        bus.win_col_out <= col - CNT_W'(1);
      end
    end
  end

  assign bus.win_out = win_q;

endmodule
